// File: rtl/wshb_sdram_arbiter.sv
// Two-master Wishbone B4 arbiter for the SDRAM controller port: VGA reader has fixed priority,
// the mire writer wins the next arbitration once it has waited MIRE_MAX_WAIT request cycles.
module wshb_sdram_arbiter #(
    parameter int ADR_W         = 32,
    parameter int DAT_W         = 16,
    parameter int SEL_W         = 2,
    parameter int MIRE_MAX_WAIT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vga_cyc,
    input  logic             vga_stb,
    input  logic             vga_we,
    input  logic [ADR_W-1:0] vga_adr,
    input  logic [SEL_W-1:0] vga_sel,
    input  logic [2:0]       vga_cti,
    input  logic [1:0]       vga_bte,
    output logic             vga_ack,
    output logic [DAT_W-1:0] vga_dat_sm,
    input  logic             mire_cyc,
    input  logic             mire_stb,
    input  logic             mire_we,
    input  logic [ADR_W-1:0] mire_adr,
    input  logic [SEL_W-1:0] mire_sel,
    input  logic [2:0]       mire_cti,
    input  logic [1:0]       mire_bte,
    input  logic [DAT_W-1:0] mire_dat_ms,
    output logic             mire_ack,
    output logic             s_cyc,
    output logic             s_stb,
    output logic             s_we,
    output logic [ADR_W-1:0] s_adr,
    output logic [SEL_W-1:0] s_sel,
    output logic [2:0]       s_cti,
    output logic [1:0]       s_bte,
    output logic [DAT_W-1:0] s_dat_ms,
    input  logic [DAT_W-1:0] s_dat_sm,
    input  logic             s_ack,
    output logic [1:0]       gnt
);

    localparam int CNT_W = $clog2(MIRE_MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MIRE_MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GNT_VGA  = 2'd1,
        GNT_MIRE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic             req_vga;
    logic             req_mire;

    assign req_vga    = vga_cyc & vga_stb;
    assign req_mire   = mire_cyc & mire_stb;
    assign vga_dat_sm = s_dat_sm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Counts how long mire has been kept off the bus; saturates so the guard stays armed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state != GNT_MIRE && state_next == GNT_MIRE) begin
            wait_cnt <= '0;
        end else if (req_mire && state != GNT_MIRE && wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_mire && wait_cnt == CNT_MAX) begin
                    state_next = GNT_MIRE;
                end else if (req_vga) begin
                    state_next = GNT_VGA;
                end else if (req_mire) begin
                    state_next = GNT_MIRE;
                end
            end
            GNT_VGA: begin
                if (!vga_cyc) begin
                    state_next = IDLE;
                end
            end
            GNT_MIRE: begin
                if (!mire_cyc) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Bus mux: the granted master drives the slave combinationally, so s_cyc drops with x_cyc.
    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_sel    = '0;
        s_cti    = 3'b000;
        s_bte    = 2'b00;
        s_dat_ms = '0;
        vga_ack  = 1'b0;
        mire_ack = 1'b0;
        gnt      = 2'b00;
        case (state)
            GNT_VGA: begin
                s_cyc   = vga_cyc;
                s_stb   = vga_stb;
                s_we    = vga_we;
                s_adr   = vga_adr;
                s_sel   = vga_sel;
                s_cti   = vga_cti;
                s_bte   = vga_bte;
                vga_ack = s_ack;
                gnt     = 2'b01;
            end
            GNT_MIRE: begin
                s_cyc    = mire_cyc;
                s_stb    = mire_stb;
                s_we     = mire_we;
                s_adr    = mire_adr;
                s_sel    = mire_sel;
                s_cti    = mire_cti;
                s_bte    = mire_bte;
                s_dat_ms = mire_dat_ms;
                mire_ack = s_ack;
                gnt      = 2'b10;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wshb_sdram_arbiter.sv
// Testbench for wshb_sdram_arbiter: directed arbitration scenarios, with every expected
// master ack queued by the stimulus and consumed by an independent ack monitor.
module tb_wshb_sdram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        vga_cyc, vga_stb, vga_we;
    logic [31:0] vga_adr;
    logic [1:0]  vga_sel;
    logic [2:0]  vga_cti;
    logic [1:0]  vga_bte;
    logic        vga_ack;
    logic [15:0] vga_dat_sm;
    logic        mire_cyc, mire_stb, mire_we;
    logic [31:0] mire_adr;
    logic [1:0]  mire_sel;
    logic [2:0]  mire_cti;
    logic [1:0]  mire_bte;
    logic [15:0] mire_dat_ms;
    logic        mire_ack;
    logic        s_cyc, s_stb, s_we;
    logic [31:0] s_adr;
    logic [1:0]  s_sel;
    logic [2:0]  s_cti;
    logic [1:0]  s_bte;
    logic [15:0] s_dat_ms;
    logic [15:0] s_dat_sm;
    logic        s_ack;
    logic [1:0]  gnt;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [1:0]  who;
        logic [15:0] rdat;
        logic [31:0] adr;
        logic        we;
        logic [15:0] wdat;
    } ack_t;

    ack_t exp_q[$];
    ack_t mon_e;
    logic vc, mc;

    always #5 clk = ~clk;

    wshb_sdram_arbiter #(
        .ADR_W(32), .DAT_W(16), .SEL_W(2), .MIRE_MAX_WAIT(64)
    ) dut (
        .clk(clk), .rst(rst),
        .vga_cyc(vga_cyc), .vga_stb(vga_stb), .vga_we(vga_we), .vga_adr(vga_adr),
        .vga_sel(vga_sel), .vga_cti(vga_cti), .vga_bte(vga_bte),
        .vga_ack(vga_ack), .vga_dat_sm(vga_dat_sm),
        .mire_cyc(mire_cyc), .mire_stb(mire_stb), .mire_we(mire_we), .mire_adr(mire_adr),
        .mire_sel(mire_sel), .mire_cti(mire_cti), .mire_bte(mire_bte),
        .mire_dat_ms(mire_dat_ms), .mire_ack(mire_ack),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_sel(s_sel),
        .s_cti(s_cti), .s_bte(s_bte), .s_dat_ms(s_dat_ms), .s_dat_sm(s_dat_sm),
        .s_ack(s_ack), .gnt(gnt)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic m, input logic c, input logic s, input logic w,
                                 input logic [31:0] a, input logic [15:0] d, input logic [2:0] t);
        if (m == 1'b0) begin
            vga_cyc = c; vga_stb = s; vga_we = w; vga_adr = a; vga_cti = t;
        end else begin
            mire_cyc = c; mire_stb = s; mire_we = w; mire_adr = a; mire_cti = t; mire_dat_ms = d;
        end
    endtask

    task automatic pushAck(input logic [1:0] who, input logic [15:0] rdat, input logic [31:0] adr,
                           input logic we, input logic [15:0] wdat);
        ack_t e;
        e.who = who; e.rdat = rdat; e.adr = adr; e.we = we; e.wdat = wdat;
        exp_q.push_back(e);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Ack monitor: every ack delivered to a master must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && (vga_ack || mire_ack)) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_ack", {30'd0, mire_ack, vga_ack}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("ack_who", {30'd0, mire_ack, vga_ack}, {30'd0, mon_e.who});
                if (mon_e.who == 2'b01) begin
                    checkOutput("ack_rdata", {16'd0, vga_dat_sm}, {16'd0, mon_e.rdat});
                end
                checkOutput("ack_adr", s_adr, mon_e.adr);
                checkOutput("ack_we", {31'd0, s_we}, {31'd0, mon_e.we});
                checkOutput("ack_wdata", {16'd0, s_dat_ms}, {16'd0, mon_e.wdat});
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time limit reached before end of stimulus");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        rst = 1'b1;
        vga_sel = 2'b11; vga_bte = 2'b00; mire_sel = 2'b11; mire_bte = 2'b00;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'hDEAD, 16'h0, 3'b000);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 16'hFFFF, 3'b000);
        s_ack = 1'b1; s_dat_sm = 16'h0;
        repeat (2) sample();
        checkOutput("rst_gnt", {30'd0, gnt}, 32'd0);
        checkOutput("rst_s_cyc", {31'd0, s_cyc}, 32'd0);
        checkOutput("rst_s_adr", s_adr, 32'd0);
        checkOutput("rst_s_dat_ms", {16'd0, s_dat_ms}, 32'd0);
        checkOutput("rst_vga_ack", {31'd0, vga_ack}, 32'd0);
        next();
        s_ack = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 3'b000);
        rst = 1'b0;

        // Async reset in the middle of a VGA grant.
        next();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 16'h0, 3'b000);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h20, 16'h1111, 3'b000);
        sample();
        checkOutput("s1_idle_gnt", {30'd0, gnt}, 32'd0);
        next();
        sample();
        checkOutput("s1_gnt_vga", {30'd0, gnt}, 32'd1);
        checkOutput("s1_s_cyc", {31'd0, s_cyc}, 32'd1);
        #1;
        s_ack = 1'b1;
        rst = 1'b1;
        #1;
        checkOutput("s1_rst_gnt", {30'd0, gnt}, 32'd0);
        checkOutput("s1_rst_s_cyc", {31'd0, s_cyc}, 32'd0);
        checkOutput("s1_rst_vga_ack", {31'd0, vga_ack}, 32'd0);
        checkOutput("s1_rst_mire_ack", {31'd0, mire_ack}, 32'd0);
        checkOutput("s1_rst_wait_cnt", {25'd0, dut.wait_cnt}, 32'd0);
        s_ack = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 3'b000);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 3'b000);
        next();
        rst = 1'b0;

        // Mire alone: write 0xABCD to 0x100, slave acks a few cycles into the grant.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 16'hABCD, 3'b000);
        sample();
        checkOutput("s2_idle_gnt", {30'd0, gnt}, 32'd0);
        next();
        sample();
        checkOutput("s2_gnt", {30'd0, gnt}, 32'd2);
        checkOutput("s2_s_cyc", {31'd0, s_cyc}, 32'd1);
        checkOutput("s2_s_we", {31'd0, s_we}, 32'd1);
        checkOutput("s2_s_adr", s_adr, 32'h100);
        checkOutput("s2_s_dat_ms", {16'd0, s_dat_ms}, 32'hABCD);
        next();
        sample();
        checkOutput("s2_no_early_ack", {31'd0, mire_ack}, 32'd0);
        next();
        s_ack = 1'b1;
        pushAck(2'b10, 16'h0, 32'h100, 1'b1, 16'hABCD);
        sample();
        checkOutput("s2_vga_ack", {31'd0, vga_ack}, 32'd0);
        next();
        s_ack = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 16'hABCD, 3'b000);
        sample();
        checkOutput("s2_release_s_cyc", {31'd0, s_cyc}, 32'd0);
        checkOutput("s2_release_gnt", {30'd0, gnt}, 32'd2);
        next();
        sample();
        checkOutput("s2_back_idle", {30'd0, gnt}, 32'd0);

        // Simultaneous requests: VGA first, IDLE turnaround, then mire.
        next();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h200, 16'h0, 3'b000);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h300, 16'h1234, 3'b000);
        sample();
        checkOutput("s3_idle_gnt", {30'd0, gnt}, 32'd0);
        next();
        s_ack = 1'b1; s_dat_sm = 16'h5A5A;
        pushAck(2'b01, 16'h5A5A, 32'h200, 1'b0, 16'h0);
        sample();
        checkOutput("s3_gnt_vga", {30'd0, gnt}, 32'd1);
        checkOutput("s3_mire_ack", {31'd0, mire_ack}, 32'd0);
        next();
        s_ack = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h200, 16'h0, 3'b000);
        sample();
        checkOutput("s3_vga_release_gnt", {30'd0, gnt}, 32'd1);
        checkOutput("s3_vga_release_s_cyc", {31'd0, s_cyc}, 32'd0);
        next();
        sample();
        checkOutput("s3_turnaround", {30'd0, gnt}, 32'd0);
        next();
        s_ack = 1'b1;
        pushAck(2'b10, 16'h0, 32'h300, 1'b1, 16'h1234);
        sample();
        checkOutput("s3_gnt_mire", {30'd0, gnt}, 32'd2);
        checkOutput("s3_s_adr", s_adr, 32'h300);
        next();
        s_ack = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h300, 16'h0, 3'b000);
        sample();
        next();
        sample();
        checkOutput("s3_end_idle", {30'd0, gnt}, 32'd0);

        // Starvation guard: mire requests continuously while VGA keeps re-requesting.
        for (int j = 0; j <= 69; j++) begin
            next();
            vc = !(j == 62 || j == 64);
            mc = (j <= 66);
            applyStimulus(1'b0, vc, vc, 1'b0, 32'h500, 16'h0, 3'b000);
            applyStimulus(1'b1, mc, mc, 1'b1, 32'h400, 16'h0F0F, 3'b000);
            sample();
            case (j)
                0: begin
                    checkOutput("s4_start_cnt", {25'd0, dut.wait_cnt}, 32'd0);
                    checkOutput("s4_start_gnt", {30'd0, gnt}, 32'd0);
                end
                1:  checkOutput("s4_vga_first", {30'd0, gnt}, 32'd1);
                62: begin
                    checkOutput("s4_vga_drop_gnt", {30'd0, gnt}, 32'd1);
                    checkOutput("s4_vga_drop_s_cyc", {31'd0, s_cyc}, 32'd0);
                end
                63: begin
                    checkOutput("s4_idle63_gnt", {30'd0, gnt}, 32'd0);
                    checkOutput("s4_cnt63", {25'd0, dut.wait_cnt}, 32'd63);
                end
                64: checkOutput("s4_vga_wins_at_63", {30'd0, gnt}, 32'd1);
                65: begin
                    checkOutput("s4_idle65_gnt", {30'd0, gnt}, 32'd0);
                    checkOutput("s4_cnt_saturated", {25'd0, dut.wait_cnt}, 32'd64);
                end
                66: begin
                    checkOutput("s4_guard_gnt", {30'd0, gnt}, 32'd2);
                    checkOutput("s4_guard_cnt_clr", {25'd0, dut.wait_cnt}, 32'd0);
                    checkOutput("s4_guard_s_adr", s_adr, 32'h400);
                end
                68: checkOutput("s4_idle68_gnt", {30'd0, gnt}, 32'd0);
                69: checkOutput("s4_vga_again", {30'd0, gnt}, 32'd1);
                default: ;
            endcase
        end
        next();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 3'b000);
        sample();
        next();
        sample();
        checkOutput("s4_end_idle", {30'd0, gnt}, 32'd0);

        // VGA 8-beat incrementing burst; mire starts requesting at beat 3.
        next();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h800, 16'h0, 3'b010);
        sample();
        checkOutput("s5_idle_gnt", {30'd0, gnt}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            next();
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'(32'h800 + i), 16'h0, (i == 7) ? 3'b111 : 3'b010);
            if (i >= 3) begin
                applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h900, 16'h7777, 3'b000);
            end
            s_ack = 1'b1;
            s_dat_sm = 16'(16'hD000 + i);
            pushAck(2'b01, 16'(16'hD000 + i), 32'(32'h800 + i), 1'b0, 16'h0);
            sample();
            checkOutput("s5_beat_gnt", {30'd0, gnt}, 32'd1);
            checkOutput("s5_beat_mire_ack", {31'd0, mire_ack}, 32'd0);
            checkOutput("s5_beat_cti", {29'd0, s_cti}, (i == 7) ? 32'd7 : 32'd2);
        end
        next();
        s_ack = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 3'b000);
        sample();
        checkOutput("s5_release_gnt", {30'd0, gnt}, 32'd1);
        next();
        sample();
        checkOutput("s5_turnaround", {30'd0, gnt}, 32'd0);
        next();
        sample();
        checkOutput("s5_gnt_mire", {30'd0, gnt}, 32'd2);
        next();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 3'b000);
        sample();
        next();
        sample();
        checkOutput("s5_end_idle", {30'd0, gnt}, 32'd0);

        // Stray slave ack while idle must reach neither master.
        next();
        s_ack = 1'b1;
        s_dat_sm = 16'hBEEF;
        sample();
        checkOutput("s6_vga_ack", {31'd0, vga_ack}, 32'd0);
        checkOutput("s6_mire_ack", {31'd0, mire_ack}, 32'd0);
        checkOutput("s6_gnt", {30'd0, gnt}, 32'd0);
        checkOutput("s6_rdata_passthru", {16'd0, vga_dat_sm}, 32'hBEEF);
        next();
        s_ack = 1'b0;
        sample();
        checkOutput("s6_stays_idle", {30'd0, gnt}, 32'd0);

        checkOutput("pending_acks", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
